// File: rtl/mult_product_accumulator_if.sv
// Handshake bundle between the array multiplier (producer), the product
// accumulator and the result consumer.
interface mult_product_accumulator_if #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 10,
  parameter int CNT_W  = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  // Producer and consumer side: offers products, accepts results.
  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  // Accumulator side.
  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/mult_product_accumulator.sv
// Sums blocks of multiplier products with saturation and presents each block
// result on a valid/ready port; a held result back-pressures the multiplier.
module mult_product_accumulator #(
  parameter int PROD_W    = 8,
  parameter int ACC_W     = 10,
  parameter int BLOCK_LEN = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  mult_product_accumulator_if.slave   bus
);

  localparam int CNT_W = $clog2(BLOCK_LEN + 1);

  localparam logic [ACC_W-1:0] ACC_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    ACC,
    HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             in_ready;
  logic             out_valid;
  logic             in_xfer;
  logic             out_xfer;
  logic [ACC_W:0]   sum_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             block_done;

  // In HOLD the input slot only opens when the result leaves in the same
  // cycle, so a new block can start back-to-back.
  assign out_valid = (state_q == HOLD);
  assign in_ready  = !rst && ((state_q == ACC) || bus.out_ready);
  assign in_xfer   = bus.in_valid && in_ready;
  assign out_xfer  = out_valid && bus.out_ready;

  // One extra bit catches the carry that signals saturation.
  assign sum_next   = {1'b0, acc_q} + (ACC_W + 1)'(bus.in_prod);
  assign cnt_inc    = cnt_q + CNT_ONE;
  assign block_done = (cnt_inc == CNT_LAST) || bus.in_last;

  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      ACC: begin
        if (in_xfer) begin
          if (sum_next[ACC_W]) begin
            acc_d = ACC_MAX;
            ovf_d = 1'b1;
          end else begin
            acc_d = sum_next[ACC_W-1:0];
          end
          cnt_d = cnt_inc;
          if (block_done) begin
            state_d = HOLD;
          end
        end
      end

      HOLD: begin
        if (out_xfer) begin
          if (in_xfer) begin
            acc_d   = ACC_W'(bus.in_prod);
            cnt_d   = CNT_ONE;
            ovf_d   = 1'b0;
            state_d = ((BLOCK_LEN == 1) || bus.in_last) ? HOLD : ACC;
          end else begin
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = ACC;
          end
        end
      end

      default: begin
        state_d = ACC;
      end
    endcase
  end

  // NOTE: asynchronous reset clears every register so a partial block is
  // dropped immediately, not at the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the
      // same pre-edge values.
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_sum   = acc_q;
  assign bus.out_count = cnt_q;
  assign bus.out_ovf   = ovf_q;

  cnt_within_block: assert property (@(posedge clk) disable iff (rst)
    cnt_q <= CNT_LAST);

  result_held: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !bus.out_ready) |=> ($stable(acc_q) && $stable(cnt_q) && $stable(ovf_q)));

endmodule
